// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel stream multiplexer.
// Mode encodings plus the wrap-around priority search used by the arbiter.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int MAX_CH = 32;

  // First set bit of req at or after ptr+1, wrapping modulo n; -1 if none.
  function automatic int rr_pick(
    input logic [MAX_CH-1:0] req,
    input int                ptr,
    input int                n
  );
    int res;
    int idx;
    res = -1;
    for (int k = 1; k <= n; k++) begin
      idx = (ptr + k) % n;
      if (res < 0 && req[idx[4:0]]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_rr_n_w_arb.sv
// Round-robin arbiter: one-hot grant searched from the slot after the
// last winner; the pointer only moves when the caller reports an accept.
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] grant,
  output logic [CW-1:0]   grant_idx
);

  logic [CW-1:0] ptr_q;
  logic [CW-1:0] ptr_d;
  int            pick;

  always_comb begin
    pick      = rr_pick(MAX_CH'(req), int'(ptr_q), N_CH);
    grant     = '0;
    grant_idx = '0;
    ptr_d     = ptr_q;
    if (pick >= 0) begin
      grant_idx        = CW'(pick);
      grant[grant_idx] = 1'b1;
      if (advance) ptr_d = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= CW'(N_CH - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_rr_n_w.sv
// N-channel W-bit stream mux with manual or round-robin channel choice
// and a single registered output stage refilled while it drains.
module mux_rr_n_w
  import mux_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int W    = 8,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [CW-1:0]     key,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [CW-1:0]     out_ch,
  input  logic              out_ready
);

  logic [N_CH-1:0] rr_grant;
  logic [CW-1:0]   rr_idx;
  logic [N_CH-1:0] man_grant;
  logic [N_CH-1:0] grant;
  logic [CW-1:0]   gidx;
  logic            load_en;
  logic            xfer;
  logic [W-1:0]    sel_data;

  logic            valid_q, valid_d;
  logic [W-1:0]    data_q, data_d;
  logic [CW-1:0]   ch_q, ch_d;

  rr_arbiter_n #(.N_CH(N_CH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (xfer && mode == MODE_RR),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // Out-of-range keys (non power-of-two N_CH) select nothing.
  always_comb begin
    man_grant = '0;
    if (int'(key) < N_CH && in_valid[key]) man_grant[key] = 1'b1;
  end

  always_comb begin
    grant    = (mode == MODE_RR) ? rr_grant : man_grant;
    gidx     = (mode == MODE_RR) ? rr_idx : key;
    load_en  = !valid_q || out_ready;
    in_ready = grant & {N_CH{load_en}};
    xfer     = |(in_valid & in_ready);
    sel_data = in_data[gidx*W +: W];
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (load_en) begin
      valid_d = xfer;
      if (xfer) begin
        data_d = sel_data;
        ch_d   = gidx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_mux_rr_n_w.sv
// Directed bench for mux_rr_n_w: default 4x8 instance plus a 3x16
// instance for the out-of-range manual key case.
module tb_mux_rr_n_w;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic        mode;
  logic [1:0]  key;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  key3;
  logic [2:0]  in_valid3;
  logic [47:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [15:0] out_data3;
  logic [1:0]  out_ch3;
  logic        out_ready3;

  always #5 clk = ~clk;

  mux_rr_n_w dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .key(key),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  mux_rr_n_w #(.N_CH(3), .W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .key(key3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
    .out_ready(out_ready3)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    mode = 1'b0; key = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    mode3 = 1'b0; key3 = '0; in_valid3 = '0; in_data3 = '0;
    out_ready3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_ch} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset4 got v=%b d=%h ch=%0d want 0/00/0",
               out_valid, out_data, out_ch);
    end
    n_cmp++;
    if ({out_valid3, out_data3, out_ch3} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset3 got v=%b d=%h ch=%0d want 0/0000/0",
               out_valid3, out_data3, out_ch3);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    @(negedge clk);
    mode = 1'b0; key = 2'd2; in_valid = 4'b0100;
    in_data = 32'h00A5_0000; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL man_ready got %b want 0100", in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      n_bad++;
      $display("FAIL man_out got v=%b d=%h ch=%0d want 1/a5/2",
               out_valid, out_data, out_ch);
    end
    @(negedge clk);
    in_valid = '0;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL man_drain got v=%b d=%h want 0/a5", out_valid, out_data);
    end
  endtask

  task automatic test_rr_all();
    @(negedge clk);
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'h1312_1110;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL rr_first_ready got %b want 0001", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== 2'(i % 4) ||
          out_data !== 8'(8'h10 + i % 4)) begin
        n_bad++;
        $display("FAIL rr_seq[%0d] got v=%b ch=%0d d=%h want 1/%0d/%h",
                 i, out_valid, out_ch, out_data, i % 4, 8'h10 + i % 4);
      end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      key = 2'(i); mode = 1'(i); in_data = 32'hDEAD_BE00 + 32'(i);
      #1;
      n_cmp++;
      if (in_ready !== 4'b0000) begin
        n_bad++;
        $display("FAIL stall_ready[%0d] got %b want 0000", i, in_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h13 || out_ch !== 2'd3) begin
        n_bad++;
        $display("FAIL stall_hold[%0d] got v=%b d=%h ch=%0d want 1/13/3",
                 i, out_valid, out_data, out_ch);
      end
      @(negedge clk);
    end
    mode = 1'b1; in_data = 32'h1312_1110; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL stall_ptr got %b want 0001", in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_ch !== 2'd0 || out_data !== 8'h10) begin
      n_bad++;
      $display("FAIL stall_resume got ch=%0d d=%h want 0/10", out_ch, out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ch [4];
    logic [3:0] vld [4];
    exp_ch = '{2'd3, 2'd3, 2'd1, 2'd3};
    vld    = '{4'b1000, 4'b1000, 4'b1010, 4'b1010};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = vld[i];
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== exp_ch[i] ||
          out_data !== 8'h10 + 8'(exp_ch[i])) begin
        n_bad++;
        $display("FAIL b2b[%0d] got v=%b ch=%0d d=%h want 1/%0d",
                 i, out_valid, out_ch, out_data, exp_ch[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_ch} !== 11'd0) begin
      n_bad++;
      $display("FAIL mid_reset got v=%b d=%h ch=%0d want 0/00/0",
               out_valid, out_data, out_ch);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin
      n_bad++;
      $display("FAIL post_reset got v=%b ch=%0d d=%h want 1/0/10",
               out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_n3_key();
    @(negedge clk);
    mode3 = 1'b0; key3 = 2'd3; in_valid3 = 3'b111;
    in_data3 = 48'hB002_B001_B000; out_ready3 = 1'b1;
    #1;
    n_cmp++;
    if (in_ready3 !== 3'b000) begin
      n_bad++;
      $display("FAIL n3_key3_ready got %b want 000", in_ready3);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid3 !== 1'b0) begin
      n_bad++;
      $display("FAIL n3_key3_out got v=%b want 0", out_valid3);
    end
    @(negedge clk);
    key3 = 2'd1;
    #1;
    n_cmp++;
    if (in_ready3 !== 3'b010) begin
      n_bad++;
      $display("FAIL n3_key1_ready got %b want 010", in_ready3);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid3 !== 1'b1 || out_data3 !== 16'hB001 || out_ch3 !== 2'd1) begin
      n_bad++;
      $display("FAIL n3_key1_out got v=%b d=%h ch=%0d want 1/b001/1",
               out_valid3, out_data3, out_ch3);
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_rr_all();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_n3_key();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_n_w.md
Name: mux_rr_n_w

Overview:
- Parametrised N-channel, W-bit stream multiplexer; successor to the fixed 4:1 x 8-bit selector.
- Two modes:
  - manual: channel chosen by `key`.
  - round-robin: fair arbitration among valid channels.
- Per-channel valid/ready handshake; single registered output stage.
- Sits between parallel producers (ALU/register sources) and a single shared consumer bus.

Parameters:
- N_CH, 4, number of input channels (>=2).
- W, 8, data width per channel.
- CW, $clog2(N_CH), channel index width (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = manual select by key, 1 = round-robin.
- key  in  CW  channel select in manual mode; ignored in round-robin.
- in_valid  in  N_CH  per-channel data valid.
- in_data  in  N_CH*W  channel i occupies bits [i*W +: W].
- in_ready  out  N_CH  per-channel accept; one-hot or zero.
- out_valid  out  1  output register holds data.
- out_data  out  W  registered selected data.
- out_ch  out  CW  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts output.

Behaviour:
- Reset (async assert, sync deassert at the bench): out_valid=0, out_data=0, out_ch=0, rr pointer=N_CH-1. Channel 0 has first priority after reset.
- load_en = !out_valid || out_ready. The output register is refilled in the same cycle it drains, giving full throughput of 1 beat/cycle.
- Grant is combinational; at most one bit set.
- Manual mode:
  - grant[key] = in_valid[key].
  - key >= N_CH (non-power-of-2 N_CH) grants nothing.
- Round-robin mode:
  - Search starts at ptr+1 and wraps modulo N_CH.
  - The first channel with in_valid=1 is granted.
- in_ready[i] = grant[i] && load_en.
- Transfer on channel i: in_valid[i] && in_ready[i]. On the next edge out_data<=in_data[i], out_ch<=i, out_valid<=1.
- If load_en=1 and no grant: out_valid<=0; out_data and out_ch hold their old values.
- Latency: 1 cycle from input transfer to out_valid.
- Stall: out_valid=1 && out_ready=0 gives in_ready=0 on all channels. out_data and out_ch are held stable regardless of key, mode or input changes.
- rr pointer:
  - Updates to the granted index only on an accepted transfer. No transfer, no change.
  - Updates only in round-robin mode; manual transfers do not move it.
- Mode or key change takes effect combinationally on grant. Already-registered output data is never altered.
- All channels valid in round-robin with out_ready=1: grants rotate ptr+1, ptr+2, ... with no channel starved beyond N_CH-1 cycles.
- A single valid channel in round-robin is granted every cycle (back-to-back allowed).
- Reset asserted mid-transfer: output cleared immediately; pending data is dropped, with no replay.
- No combinational path from in_data to out_data. The only combinational path to in_ready is from in_valid, key, mode, out_ready and state.

Decomposition:
- Package mux_pkg:
  - MODE_MANUAL=1'b0, MODE_RR=1'b1.
  - Helper function for the wrap-around priority search.
- Sub-module rr_arbiter_n (params N_CH): inputs req[N_CH], advance, clk, rst_n; outputs grant[N_CH] (one-hot), grant_idx[CW]. Owns the pointer register.
- Top instantiates rr_arbiter_n plus the manual-select path, the grant mux and the output register.

Test Plan:
- Reset, then manual mode, key=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_ch=2.
- Round-robin, all in_valid=1, data ch_i=8'h10+i, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3; data 10,11,12,13,...
- Output stall: out_valid=1, out_ready=0 for 3 cycles while key and in_data change -> in_ready=0; out_data and out_ch unchanged; pointer unchanged.
- Round-robin, only ch3 valid, then ch1 and ch3 valid -> ch3 granted; next grant is ch1 (wrap from ptr=3), then ch3.
- Reset asserted mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately. After release, all channels valid gives first grant ch0.
- N_CH=3, W=16, manual key=3 with all valid -> in_ready=0, out_valid stays 0. Switch to key=1 -> ch1 data out next cycle.
